// File: rtl/gemm_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// gemm_ctrl_pkg
// Shared types and constants for the GEMM tile loop-nest controller.
//   DIM_WIDTH_DEFAULT : default width of tile counts and tile indices
//   seq_state_e       : sequencer FSM states (IDLE, RUN, DONE)
//   tile_idx_t        : packed {m, n, k} tile index for downstream stages
// ----------------------------------------------------------------------------
package gemm_ctrl_pkg;

    localparam int DIM_WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic [DIM_WIDTH_DEFAULT-1:0] m;
        logic [DIM_WIDTH_DEFAULT-1:0] n;
        logic [DIM_WIDTH_DEFAULT-1:0] k;
    } tile_idx_t;

endpackage : gemm_ctrl_pkg

// File: rtl/ceiling_counter.sv
// ----------------------------------------------------------------------------
// ceiling_counter
// One loop level of a nested counter. Counts 0..ceiling-1 and wraps to 0.
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   clear_i        : synchronous clear to 0, dominates tick_i
//   tick_i         : advance by one
//   ceiling_i      : wrap point (count of values); must be nonzero while ticking
//   value_o        : current count
//   last_value_o   : tick_i while value_o is the final value, i.e. the carry
//                    into the next outer loop level
// With HasCeiling=0 the counter ignores ceiling_i and wraps at all-ones.
// ----------------------------------------------------------------------------
module ceiling_counter #(
    parameter int Width      = 16,
    parameter bit HasCeiling = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             tick_i,
    input  logic [Width-1:0] ceiling_i,
    output logic [Width-1:0] value_o,
    output logic             last_value_o
);

    logic [Width-1:0] r_value;
    logic             w_at_last;

    generate
        if (HasCeiling) begin : g_ceiling
            assign w_at_last = (r_value == (ceiling_i - Width'(1)));
        end else begin : g_free
            logic w_unused_ceiling;
            assign w_unused_ceiling = |ceiling_i;
            assign w_at_last        = &r_value;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_value <= '0;
        end else if (clear_i) begin
            r_value <= '0;
        end else if (tick_i) begin
            if (w_at_last) begin
                r_value <= '0;
            end else begin
                r_value <= r_value + Width'(1);
            end
        end
    end

    assign value_o      = r_value;
    assign last_value_o = tick_i & w_at_last;

endmodule : ceiling_counter

// File: rtl/gemm_tile_sequencer.sv
// ----------------------------------------------------------------------------
// gemm_tile_sequencer
// Loop-nest controller for the GEMM datapath. Latches M/N/K tile counts on a
// start pulse and issues every (m, n, k) index, M outer / N middle / K inner,
// over a valid/ready handshake.
// Ports:
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   start_i                : start request, honoured only in IDLE
//   abort_i                : synchronous abort back to IDLE, no done pulse
//   m/n/k_size_i           : tile counts, sampled on the accepted start
//   idx_valid_o/idx_ready_i: index handshake
//   m/n/k_idx_o            : current tile index
//   k_first_o / k_last_o   : first / last K step of the current (m, n) tile
//   busy_o                 : high in RUN and DONE
//   done_o                 : one-cycle completion pulse
// ----------------------------------------------------------------------------
module gemm_tile_sequencer
    import gemm_ctrl_pkg::*;
#(
    parameter int DimWidth = DIM_WIDTH_DEFAULT
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic [DimWidth-1:0] m_size_i,
    input  logic [DimWidth-1:0] n_size_i,
    input  logic [DimWidth-1:0] k_size_i,
    output logic                idx_valid_o,
    input  logic                idx_ready_i,
    output logic [DimWidth-1:0] m_idx_o,
    output logic [DimWidth-1:0] n_idx_o,
    output logic [DimWidth-1:0] k_idx_o,
    output logic                k_first_o,
    output logic                k_last_o,
    output logic                busy_o,
    output logic                done_o
);

    seq_state_e r_state;
    seq_state_e w_state_next;

    logic [DimWidth-1:0] r_m_size;
    logic [DimWidth-1:0] r_n_size;
    logic [DimWidth-1:0] r_k_size;

    logic w_start_req;
    logic w_sizes_nonzero;
    logic w_fire;
    logic w_clear;
    logic w_k_wrap;
    logic w_n_wrap;
    logic w_all_last;

    // A start seen in IDLE clears the counters even when abort_i is also high;
    // both lead to the same cleared state, so no extra gating is needed there.
    assign w_start_req     = (r_state == IDLE) & start_i;
    assign w_sizes_nonzero = (m_size_i != '0) & (n_size_i != '0) & (k_size_i != '0);
    assign w_fire          = idx_valid_o & idx_ready_i;
    assign w_clear         = abort_i | w_start_req;

    // Sizes are only captured for a job that will actually run; a zero-size
    // start or an aborted start leaves the previous values untouched.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_m_size <= '0;
            r_n_size <= '0;
            r_k_size <= '0;
        end else if (w_start_req && !abort_i && w_sizes_nonzero) begin
            r_m_size <= m_size_i;
            r_n_size <= n_size_i;
            r_k_size <= k_size_i;
        end
    end

    // Carry chain: k ticks on every handshake, n on k's wrap, m on n's wrap.
    // The wrap of m is the handshake that finishes the whole loop nest.
    ceiling_counter #(
        .Width      (DimWidth),
        .HasCeiling (1'b1)
    ) u_k_cnt (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (w_clear),
        .tick_i       (w_fire),
        .ceiling_i    (r_k_size),
        .value_o      (k_idx_o),
        .last_value_o (w_k_wrap)
    );

    ceiling_counter #(
        .Width      (DimWidth),
        .HasCeiling (1'b1)
    ) u_n_cnt (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (w_clear),
        .tick_i       (w_k_wrap),
        .ceiling_i    (r_n_size),
        .value_o      (n_idx_o),
        .last_value_o (w_n_wrap)
    );

    ceiling_counter #(
        .Width      (DimWidth),
        .HasCeiling (1'b1)
    ) u_m_cnt (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (w_clear),
        .tick_i       (w_n_wrap),
        .ceiling_i    (r_m_size),
        .value_o      (m_idx_o),
        .last_value_o (w_all_last)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        idx_valid_o  = 1'b0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_state_next = w_sizes_nonzero ? RUN : DONE;
                end
            end
            RUN: begin
                idx_valid_o = 1'b1;
                busy_o      = 1'b1;
                if (w_all_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                busy_o       = 1'b1;
                done_o       = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
        if (abort_i) begin
            w_state_next = IDLE;
        end
    end

    assign k_first_o = idx_valid_o & (k_idx_o == '0);
    assign k_last_o  = idx_valid_o & (k_idx_o == (r_k_size - DimWidth'(1)));

endmodule : gemm_tile_sequencer

// File: tb/tb_gemm_tile_sequencer.sv
// ----------------------------------------------------------------------------
// tb_gemm_tile_sequencer
// Self-checking bench for gemm_tile_sequencer. The expected index for the
// f-th handshake of an MxNxK job is derived arithmetically:
//   k = f % K, n = (f / K) % N, m = f / (N*K)
// Inputs are driven and outputs sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_gemm_tile_sequencer;

    localparam int DW = 16;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          start_i;
    logic          abort_i;
    logic [DW-1:0] m_size_i;
    logic [DW-1:0] n_size_i;
    logic [DW-1:0] k_size_i;
    logic          idx_valid_o;
    logic          idx_ready_i;
    logic [DW-1:0] m_idx_o;
    logic [DW-1:0] n_idx_o;
    logic [DW-1:0] k_idx_o;
    logic          k_first_o;
    logic          k_last_o;
    logic          busy_o;
    logic          done_o;

    int n_vec = 0;
    int n_err = 0;

    gemm_tile_sequencer #(.DimWidth(DW)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .m_size_i    (m_size_i),
        .n_size_i    (n_size_i),
        .k_size_i    (k_size_i),
        .idx_valid_o (idx_valid_o),
        .idx_ready_i (idx_ready_i),
        .m_idx_o     (m_idx_o),
        .n_idx_o     (n_idx_o),
        .k_idx_o     (k_idx_o),
        .k_first_o   (k_first_o),
        .k_last_o    (k_last_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entry and exit points are just after a falling edge.
    // abort_at: fire number (1-based) that is accompanied by abort, 0 = none.
    // start_mid_at: RUN cycle on which a stray start is raised, -1 = none.
    task automatic run_job(input int m, input int n, input int k, input bit rand_ready,
                           input int abort_at, input int start_mid_at);
        int  total;
        int  fires;
        int  cyc;
        int  budget;
        bit  aborted;
        bit  rdy;
        logic [47:0] exp_idx;
        total   = m * n * k;
        fires   = 0;
        cyc     = 0;
        aborted = 1'b0;
        budget  = total * 30 + 20;
        $display("job %0dx%0dx%0d rand_ready=%0d abort_at=%0d start_mid=%0d",
                 m, n, k, rand_ready, abort_at, start_mid_at);
        chk("idle_valid", idx_valid_o, 0);
        chk("idle_busy", busy_o, 0);
        start_i  = 1'b1;
        m_size_i = DW'(m);
        n_size_i = DW'(n);
        k_size_i = DW'(k);
        @(negedge clk_i);
        start_i  = 1'b0;
        m_size_i = DW'($urandom);
        n_size_i = DW'($urandom);
        k_size_i = DW'($urandom);
        if (total == 0) begin
            chk("zero_valid", idx_valid_o, 0);
            chk("zero_done", done_o, 1);
            chk("zero_busy", busy_o, 1);
            @(negedge clk_i);
            chk("zero_done_end", done_o, 0);
            chk("zero_busy_end", busy_o, 0);
            return;
        end
        while (fires < total && !aborted && cyc < budget) begin
            exp_idx = {DW'(fires / (n * k)), DW'((fires / k) % n), DW'(fires % k)};
            chk("valid", idx_valid_o, 1);
            chk("idx", {m_idx_o, n_idx_o, k_idx_o}, exp_idx);
            chk("k_first", k_first_o, (fires % k) == 0);
            chk("k_last", k_last_o, (fires % k) == k - 1);
            chk("run_done", done_o, 0);
            chk("run_busy", busy_o, 1);
            rdy = rand_ready ? 1'($urandom) : 1'b1;
            idx_ready_i = rdy;
            if (rdy && fires + 1 == abort_at) abort_i = 1'b1;
            if (cyc == start_mid_at) begin
                start_i  = 1'b1;
                m_size_i = 1;
                n_size_i = 3;
                k_size_i = 1;
            end
            @(negedge clk_i);
            start_i = 1'b0;
            abort_i = 1'b0;
            if (rdy) begin
                fires++;
                if (fires == abort_at) aborted = 1'b1;
            end
            cyc++;
        end
        idx_ready_i = 1'($urandom);
        if (aborted) begin
            chk("abort_valid", idx_valid_o, 0);
            chk("abort_done", done_o, 0);
            chk("abort_busy", busy_o, 0);
            @(negedge clk_i);
            chk("abort_done_later", done_o, 0);
            return;
        end
        chk("fire_count", fires, total);
        chk("end_valid", idx_valid_o, 0);
        chk("end_done", done_o, 1);
        chk("end_busy", busy_o, 1);
        @(negedge clk_i);
        chk("post_done", done_o, 0);
        chk("post_busy", busy_o, 0);
        chk("post_valid", idx_valid_o, 0);
    endtask

    initial begin
        rst_ni      = 1'b0;
        start_i     = 1'b0;
        abort_i     = 1'b0;
        idx_ready_i = 1'b0;
        m_size_i    = '0;
        n_size_i    = '0;
        k_size_i    = '0;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("rst_valid", idx_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_idx", {m_idx_o, n_idx_o, k_idx_o}, 0);
        chk("rst_flags", {k_first_o, k_last_o}, 0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        run_job(2, 2, 3, 1'b0, 0, -1);
        run_job(2, 2, 3, 1'b1, 0, -1);
        run_job(1, 1, 1, 1'b0, 0, -1);
        run_job(3, 0, 4, 1'b0, 0, -1);
        run_job(2, 2, 3, 1'b1, 0, 3);
        run_job(2, 2, 3, 1'b0, 5, -1);
        run_job(1, 1, 2, 1'b0, 0, -1);

        for (int i = 0; i < 20; i++) begin
            run_job($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4),
                    1'b1, 0, -1);
        end

        // Reset in the middle of a running job.
        $display("job 2x2x3 with mid-run reset");
        start_i  = 1'b1;
        m_size_i = 2;
        n_size_i = 2;
        k_size_i = 3;
        idx_ready_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("pre_rst_valid", idx_valid_o, 1);
        #2 rst_ni = 1'b0;
        #1;
        chk("mid_rst_valid", idx_valid_o, 0);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_done", done_o, 0);
        chk("mid_rst_idx", {m_idx_o, n_idx_o, k_idx_o}, 0);
        chk("mid_rst_flags", {k_first_o, k_last_o}, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        run_job(1, 1, 2, 1'b0, 0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_gemm_tile_sequencer

// File: doc/gemm_tile_sequencer.md
Name: gemm_tile_sequencer

Overview:
Loop-nest controller for the GEMM datapath. It latches the M/N/K tile counts on a start pulse, then walks every (m, n, k) tile index in M-outer, N-middle, K-inner order. Each index is issued over a valid/ready handshake to the operand-fetch / PE-array stage. It also flags the first and last K step, for accumulator clear and writeback, and reports busy/done to the top-level CSR block.

Parameters:
DimWidth, 16, width of every tile count and tile index; legal counts are 0..2^DimWidth-1.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  one-cycle start request; honoured only in IDLE
abort_i  in  1  synchronous abort; returns to IDLE without done
m_size_i  in  DimWidth  number of M tiles
n_size_i  in  DimWidth  number of N tiles
k_size_i  in  DimWidth  number of K tiles
idx_valid_o  out  1  current tile index is valid
idx_ready_i  in  1  downstream accepts index
m_idx_o  out  DimWidth  current M tile index
n_idx_o  out  DimWidth  current N tile index
k_idx_o  out  DimWidth  current K tile index
k_first_o  out  1  k_idx_o == 0 while valid (accumulator clear)
k_last_o  out  1  k_idx_o == k_size-1 while valid (accumulator writeback)
busy_o  out  1  high in RUN and DONE
done_o  out  1  one-cycle pulse when the loop nest completes

Behaviour:
- Reset, asynchronous and active-low:
  - state = IDLE.
  - Counters and latched sizes = 0.
  - All outputs = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start_i=1 with all three sizes nonzero: latch sizes into internal regs; next cycle RUN.
  - start_i=1 with any size == 0: latch nothing; next cycle DONE. The zero-work job completes with zero handshakes.
  - Otherwise stay in IDLE. Size inputs are ignored outside the start cycle.
- RUN:
  - idx_valid_o=1 on the first RUN cycle; indices start at (0,0,0). Latency from start_i to first valid is 1 cycle.
  - Handshake fires on idx_valid_o & idx_ready_i.
  - Without a handshake, indices, k_first_o and k_last_o hold stable and valid stays high.
  - On a handshake, k advances.
  - When k is at k_size-1 and fires, k wraps to 0 and n advances.
  - When n also wraps, m advances.
  - On the handshake where m, n and k are all last, go to DONE; idx_valid_o drops the next cycle.
  - Issues exactly M*N*K handshakes, back-to-back at one per cycle under constant ready.
- DONE: done_o=1 and idx_valid_o=0 for exactly one cycle; then IDLE. busy_o drops together with the return to IDLE.
- Abort:
  - abort_i in any state: next cycle IDLE, counters cleared, no done pulse.
  - abort_i has priority over start_i and over a same-cycle handshake; that handshake still counts as accepted downstream.
- start_i in RUN or DONE is ignored; it is not queued.
- Counter widths: the k/n/m counters are DimWidth wide, wrapping at the latched size minus 1. No counter ever exceeds size-1.
- k_first_o and k_last_o are combinational from k_idx_o and the latched k_size, gated by idx_valid_o. Both are high when k_size == 1.

Decomposition:
- Package gemm_ctrl_pkg holds:
  - DimWidth default.
  - seq_state_e enum: IDLE, RUN, DONE.
  - The tile-index struct {m, n, k} for downstream reuse.
- Sub-modules: three ceiling_counter instances with HasCeiling=1, one per loop level.
  - Ceiling = latched size.
  - Tick for k = handshake fire.
  - Tick for n = k last_value; tick for m = n last_value.
  - clear = abort or start accepted.
  - The all-last condition is the m last_value output.
- FSM and handshake glue live in gemm_tile_sequencer itself.

Test Plan:
- M=2,N=2,K=3, ready tied high, start pulse:
  - First valid 1 cycle after start; 12 consecutive handshakes.
  - Order (0,0,0),(0,0,1),(0,0,2),(0,1,0)…(1,1,2).
  - k_first_o on k=0; k_last_o on k=2.
  - done_o one cycle after the 12th fire, then busy_o=0.
- Same job with ready toggled pseudo-randomly:
  - Indices stable while valid & !ready.
  - Still exactly 12 fires in the same order; a single done pulse.
- M=1,N=1,K=1: one fire with k_first_o=k_last_o=1; done_o the next cycle.
- M=3,N=0,K=4: zero handshakes; done_o pulses 1 cycle after start.
- start_i reasserted mid-RUN with different sizes: ignored; the original sequence completes unchanged.
- abort_i at the 5th fire of 2×2×3:
  - Valid low the next cycle; no done pulse; back in IDLE.
  - A new 1×1×2 start produces (0,0,0),(0,0,1) and done.
  - Repeat with rst_ni asserted mid-RUN: all outputs 0 immediately.
